// File: rtl/inst_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, instruction
// classes and the instruction bit positions that select them.
package inst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_DP  = 2'd0,
    CLS_JC  = 2'd1,
    CLS_JMP = 2'd2,
    CLS_HLT = 2'd3
  } inst_class_e;

  // Raw values of the two-bit class field at the top of the instruction.
  localparam logic [1:0] FIELD_JC   = 2'b10;
  localparam logic [1:0] FIELD_JUMP = 2'b11;

  function automatic int class_hi_bit(input int inst_width);
    return inst_width - 1;
  endfunction

  function automatic int halt_bit(input int inst_width);
    return inst_width - 3;
  endfunction

endpackage

// File: rtl/inst_sequencer_pc_reg.sv
// Program counter: load has priority over increment; increment wraps
// modulo 2**PC_WIDTH.
module inst_sequencer_pc_reg #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + PC_ONE;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/decode/execute controller: fetches words from program ROM over a
// req/ack handshake, holds the instruction for the datapath, resolves jumps.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH    = 4,
  parameter int INST_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 5,
  parameter int PC_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  rom_req,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic                  rom_ack,
  input  logic [INST_WIDTH-1:0] rom_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  dp_we,
  input  logic                  alu_cout,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halt
);

  localparam int CLS_HI  = class_hi_bit(INST_WIDTH);
  localparam int HLT_BIT = halt_bit(INST_WIDTH);

  // Parameter sets that leave no room for class, halt and target fields.
  if (OPCODE_WIDTH >= INST_WIDTH || BIT_WIDTH < 1 || PC_WIDTH > HLT_BIT) begin : g_bad_params
  end

  state_e                state_d, state_q;
  logic [INST_WIDTH-1:0] inst_d, inst_q;
  logic                  cflag_d, cflag_q;
  logic                  rom_req_d, rom_req_q;
  logic                  dp_we_d, dp_we_q;
  logic                  halt_d, halt_q;
  logic                  pc_load_s;
  logic                  pc_inc_s;
  inst_class_e           cls_s;
  logic [PC_WIDTH-1:0]   pc_s;

  always_comb begin
    cls_s = CLS_DP;
    case (inst_q[CLS_HI -: 2])
      FIELD_JC:   cls_s = CLS_JC;
      FIELD_JUMP: begin
        if (inst_q[HLT_BIT]) begin
          cls_s = CLS_HLT;
        end else begin
          cls_s = CLS_JMP;
        end
      end
      default:    cls_s = CLS_DP;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    cflag_d   = cflag_q;
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rom_ack) begin
          inst_d  = rom_data;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (cls_s)
          CLS_DP: begin
            cflag_d  = alu_cout;
            pc_inc_s = 1'b1;
          end
          CLS_JC: begin
            if (cflag_q) begin
              pc_load_s = 1'b1;
            end else begin
              pc_inc_s = 1'b1;
            end
          end
          CLS_JMP: pc_load_s = 1'b1;
          default: pc_load_s = 1'b0;
        endcase
        if (cls_s == CLS_HLT) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they are glitch-free.
    rom_req_d = (state_d == ST_FETCH);
    dp_we_d   = (state_d == ST_EXEC) && (cls_s == CLS_DP);
    halt_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= '0;
      cflag_q   <= 1'b0;
      rom_req_q <= 1'b0;
      dp_we_q   <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      cflag_q   <= cflag_d;
      rom_req_q <= rom_req_d;
      dp_we_q   <= dp_we_d;
      halt_q    <= halt_d;
    end
  end

  inst_sequencer_pc_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load_s),
    .inc    (pc_inc_s),
    .target (inst_q[PC_WIDTH-1:0]),
    .pc     (pc_s)
  );

  assign pc       = pc_s;
  assign rom_addr = pc_s;
  assign rom_req  = rom_req_q;
  assign inst     = inst_q;
  assign dp_we    = dp_we_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with a small ROM responder of
// programmable ack latency.
module tb_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [7:0] inst;
  logic       dp_we;
  logic       alu_cout;
  logic [3:0] pc;
  logic       halt;

  logic [7:0] mem [16];
  int         ack_delay;
  int         wait_cnt;
  logic       ack_force_en;
  logic       ack_force_val;

  int checks = 0;
  int errors = 0;

  int req_cnt;
  int we_cnt;
  int halt_cnt;
  int addr_bad;

  always #5 clk = ~clk;

  inst_sequencer #(
    .BIT_WIDTH(4), .INST_WIDTH(8), .OPCODE_WIDTH(5), .PC_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .inst     (inst),
    .dp_we    (dp_we),
    .alu_cout (alu_cout),
    .pc       (pc),
    .halt     (halt)
  );

  // ROM responder: ack once rom_req has been high for ack_delay cycles.
  always @(posedge clk) begin
    if (rom_req) wait_cnt <= wait_cnt + 1;
    else         wait_cnt <= 0;
  end

  assign rom_ack  = ack_force_en ? ack_force_val : (rom_req && (wait_cnt >= ack_delay));
  assign rom_data = mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'hE0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    #1;
    step();
    rst = 1'b1;
  endtask

  task automatic jc_case(input logic cout_dp, input logic cout_jc, input logic [3:0] exp_pc);
    fill_mem();
    mem[0] = 8'h15;
    mem[1] = 8'h87;
    ack_delay = 0;
    do_reset();
    run = 1'b1;
    alu_cout = cout_dp;
    repeat (4) step();
    alu_cout = cout_jc;
    run = 1'b0;
    step();
    step();
    check("jc_inst", inst, 8'h87);
    check("jc_no_we", dp_we, 1'b0);
    step();
    check("jc_pc", pc, exp_pc);
  endtask

  initial begin
    wait_cnt = 0;
    rst = 1'b0;
    run = 1'b0;
    alu_cout = 1'b0;
    ack_delay = 0;
    ack_force_en = 1'b0;
    ack_force_val = 1'b0;
    fill_mem();
    #3;
    check("rst_req", rom_req, 1'b0);
    check("rst_we", dp_we, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_pc", pc, 4'd0);
    check("rst_inst", inst, 8'h00);

    // Single DP word with immediate ack.
    mem[0] = 8'h15;
    do_reset();
    run = 1'b1;
    step();
    check("t1_req", rom_req, 1'b1);
    check("t1_addr", rom_addr, 4'd0);
    step();
    check("t1_req_drop", rom_req, 1'b0);
    check("t1_inst", inst, 8'h15);
    check("t1_we_early", dp_we, 1'b0);
    step();
    check("t1_we", dp_we, 1'b1);
    check("t1_pc_hold", pc, 4'd0);
    step();
    check("t1_we_off", dp_we, 1'b0);
    check("t1_pc", pc, 4'd1);
    check("t1_refetch", rom_req, 1'b1);

    // Ack latency of 4, with run dropped during the fetch.
    fill_mem();
    mem[0] = 8'h15;
    mem[1] = 8'h15;
    ack_delay = 4;
    do_reset();
    run = 1'b1;
    req_cnt = 0;
    we_cnt = 0;
    addr_bad = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 1) run = 1'b0;
      if (rom_req) begin
        req_cnt++;
        if (rom_addr != 4'd0) addr_bad++;
      end
      if (dp_we) we_cnt++;
    end
    check("t2_req_cycles", req_cnt, 5);
    check("t2_we_pulses", we_cnt, 1);
    check("t2_addr_stable", addr_bad, 0);
    check("t2_pc", pc, 4'd1);
    check("t2_idle_req", rom_req, 1'b0);
    run = 1'b1;
    step();
    check("t2_resume_req", rom_req, 1'b1);
    check("t2_resume_addr", rom_addr, 4'd1);
    step();
    rst = 1'b0;
    #1;
    check("t2_midfetch_req", rom_req, 1'b0);
    check("t2_midfetch_pc", pc, 4'd0);

    // Jump-if-carry uses the carry left by the previous DP, not its own.
    jc_case(1'b1, 1'b0, 4'd7);
    jc_case(1'b0, 1'b1, 4'd2);

    // JMP to 15, then JMP 0 from address 15.
    fill_mem();
    mem[0] = 8'hCF;
    mem[15] = 8'hC0;
    ack_delay = 0;
    do_reset();
    run = 1'b1;
    repeat (4) step();
    check("t4_jmp15", pc, 4'd15);
    run = 1'b0;
    repeat (3) step();
    check("t4_jmp0", pc, 4'd0);
    check("t4_idle", rom_req, 1'b0);

    // DP at address 15 wraps to 0.
    mem[15] = 8'h15;
    do_reset();
    run = 1'b1;
    repeat (4) step();
    check("t4b_pc15", pc, 4'd15);
    run = 1'b0;
    repeat (2) step();
    check("t4b_we", dp_we, 1'b1);
    step();
    check("t4b_wrap", pc, 4'd0);

    // HLT is sticky until reset.
    fill_mem();
    mem[0] = 8'h15;
    mem[1] = 8'hE0;
    do_reset();
    run = 1'b1;
    repeat (6) step();
    check("t5_halt_early", halt, 1'b0);
    step();
    check("t5_halt", halt, 1'b1);
    check("t5_pc", pc, 4'd1);
    req_cnt = 0;
    halt_cnt = 0;
    ack_force_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ack_force_val = i[0];
      step();
      if (rom_req) req_cnt++;
      if (halt) halt_cnt++;
    end
    check("t5_no_req", req_cnt, 0);
    check("t5_sticky", halt_cnt, 20);
    check("t5_pc_hold", pc, 4'd1);
    #3;
    rst = 1'b0;
    #1;
    check("t5_rst_halt", halt, 1'b0);
    check("t5_rst_pc", pc, 4'd0);
    check("t5_rst_inst", inst, 8'h00);
    ack_force_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 4-bit processor's data_path. It owns the program counter and the carry flag, fetches instruction words from program ROM over a req/ack handshake, and holds the current instruction stable for the datapath. It issues a one-cycle register write strobe per datapath instruction and resolves jumps and halts. It sits between program ROM and data_path and replaces a single-cycle PC/ROM control path.

Parameters:
BIT_WIDTH, 4, datapath word width (informational; sizes nothing internally except pass-through)
INST_WIDTH, 8, instruction word width
OPCODE_WIDTH, 5, opcode field width; immediate = inst[INST_WIDTH-OPCODE_WIDTH-1:0]
PC_WIDTH, 4, program counter width; ROM depth = 2**PC_WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
run  input  1  1 = execute program; sampled in IDLE and at end of EXEC
rom_req  output  1  fetch request, high for whole FETCH state
rom_addr  output  PC_WIDTH  fetch address, equals pc
rom_ack  input  1  ROM data valid this cycle; only meaningful while rom_req=1
rom_data  input  INST_WIDTH  instruction word, valid when rom_ack=1
inst  output  INST_WIDTH  latched current instruction, drives data_path fields
dp_we  output  1  datapath register write strobe, one cycle per datapath op
alu_cout  input  1  ALU carry from data_path
pc  output  PC_WIDTH  current program counter
halt  output  1  1 while in HALT

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, inst=0, cflag=0. Outputs rom_req=0, dp_we=0, halt=0, all asserted immediately without waiting for clk. Reset mid-fetch drops rom_req at once; the in-flight ack is ignored.
- States: IDLE, FETCH, DECODE, EXEC, HALT. Moore outputs: rom_req=(FETCH), dp_we=(EXEC and class=DP), halt=(HALT).
- IDLE: go to FETCH when run=1, else stay.
- FETCH: rom_req=1, rom_addr=pc. On rom_ack=1: inst<=rom_data, go to DECODE. Otherwise stay with rom_req held. No timeout.
- DECODE: one cycle for datapath combinational settle. Always go to EXEC.
- Instruction class from inst[INST_WIDTH-1:INST_WIDTH-2]:
  - 00/01: DP, a datapath op.
  - 10: JC, jump if carry.
  - 11 with inst[INST_WIDTH-3]=0: JMP.
  - 11 with inst[INST_WIDTH-3]=1: HLT.
  - Jump target = inst[PC_WIDTH-1:0].
- EXEC actions:
  - DP: dp_we=1; cflag<=alu_cout; pc<=pc+1.
  - JC: pc<=cflag ? target : pc+1.
  - JMP: pc<=target.
  - HLT: pc unchanged; go to HALT.
- EXEC exit, non-HLT: go to FETCH if run=1, else IDLE.
- run is ignored in FETCH/DECODE: deasserting run always completes the current instruction.
- cflag changes only on DP. JC reads the value left by the most recent DP. A JC never sees the carry of its own cycle.
- pc increment wraps modulo 2**PC_WIDTH (15+1 -> 0 at default).
- HALT is sticky: exit only by reset. run and rom_ack are ignored.
- rom_ack outside FETCH is ignored. inst holds its value from fetch until the next fetch completes.
- Minimum throughput 3 cycles/instruction (ack in the first FETCH cycle). Each extra cycle of ack latency adds one cycle.

Decomposition:
- Shared package: state encoding constants, class field values (DP/JC/JMP/HLT), class and halt bit positions as functions of INST_WIDTH.
- One sub-module is natural: pc_reg (async active-low reset, load/increment/hold, PC_WIDTH wrap).

Test Plan:
- Reset then run=1, ROM acks immediately, word 0 = 8'h15 (DP) -> rom_req at cycle 1, dp_we single pulse at cycle 3, pc 0->1, inst=8'h15.
- ROM ack delayed 4 cycles -> rom_req held 5 cycles with rom_addr stable, dp_we pulses once, no double fetch.
- DP with alu_cout=1, then JC 8'h87 -> pc=7. Repeat with alu_cout=0 -> pc=2.
- JMP 8'hC0 at address 15, and DP at address 15 -> pc=0 in both cases (target and wrap).
- HLT 8'hE0 -> halt=1, rom_req stays 0 for 20 cycles despite run=1 and rom_ack toggling. Drive rst=0 mid-cycle -> halt=0, pc=0 immediately.
- run dropped during FETCH -> instruction completes, state returns to IDLE, rom_req stays 0. run reasserted -> fetch resumes at the next pc.
